nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit ripple-carry slice over successive cycles. Least-significant nibble goes first, and the carry is registered between slices. It accepts one operation at a time through a valid/ready input handshake and returns the result through a valid/ready output handshake. It sits between arithmetic clients and the shared 4-bit adder datapath, and trades latency for area on wide operands.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 27 ++
 rtl/nibble_serial_adder_ctrl_nibble_adder.sv | 25 ++
 rtl/nibble_serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// slice width, FSM state codes and sizing helpers.
package nibble_serial_adder_ctrl_pkg;

    // Width of the single shared ripple-carry slice.
    localparam int SLICE_W = 4;

    // FSM state codes.
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Number of nibble slices needed to cover an operand of the given width.
    function automatic int nslice(input int width);
        return width / SLICE_W;
    endfunction

    // Width of the slice index counter; kept at least one bit so a
    // single-slice build still has a legal counter register.
    function automatic int idx_w(input int width);
        int n;
        n = nslice(width);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry adder slice shared by every step of
// a serial add/subtract.
module nibble_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] carry;

    assign carry[0] = cin;

    // Classic ripple chain: each bit produces its sum and passes the carry up.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequencer that reuses one 4-bit ripple slice over
// NSLICE cycles, least-significant nibble first, with the carry registered
// between slices. Operations enter and results leave through valid/ready.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = nslice(WIDTH);
    localparam int IW     = idx_w(WIDTH);
    localparam logic [IW-1:0] K_LAST = IW'(NSLICE - 1);

    // Operand width must be a whole number of slices.
    if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // The current nibble of each operand, selected by the slice index.
    assign slice_a = op_a_q[k_q*SLICE_W +: SLICE_W];
    assign slice_b = op_b_q[k_q*SLICE_W +: SLICE_W];

    nibble_adder u_nibble_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state logic: accept in IDLE, one slice per cycle in RUN,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + carry, where carry = ~cin
                    // turns the borrow-in into the two's complement +1.
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    k_d     = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[k_q*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (k_q == K_LAST) begin
                    cout_d  = slice_cout;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: a 16-bit and a 4-bit
// instance driven with directed and random operations, compared against an
// arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        in_valid_4, in_ready_4, cin_4, sub_4, out_valid_4, out_ready_4, cout_4, busy_4;
    logic [3:0]  a_4, b_4, sum_4;

    int checks   = 0;
    int failures = 0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut_4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_4), .in_ready(in_ready_4),
        .a(a_4), .b(b_4), .cin(cin_4), .sub(sub_4),
        .out_valid(out_valid_4), .out_ready(out_ready_4),
        .sum(sum_4), .cout(cout_4), .busy(busy_4)
    );

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned operands.
    function automatic void model(input int w, input longint ma, input longint mb,
                                  input longint mc, input bit ms,
                                  output longint msum, output bit mcout);
        longint mask;
        longint r;
        mask = (longint'(1) << w) - 1;
        if (!ms) begin
            r     = ma + mb + mc;
            msum  = r & mask;
            mcout = ((r >> w) & 1) != 0;
        end else begin
            r     = ma - mb - mc;
            msum  = r & mask;
            mcout = (ma >= mb + mc);
        end
    endfunction

    // One full 16-bit operation: accept, measure latency, optional
    // backpressure, then handshake out.
    task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tb_b,
                                  input logic tcin, input logic tsub,
                                  input logic [15:0] esum, input logic ecout,
                                  input int hold, input bit early_ready, input string tag);
        int lat;
        check_output({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        a = ta; b = tb_b; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        if (early_ready) out_ready = 1'b1;
        check_output({tag, ".busy_run"}, 32'(busy), 32'd1);
        check_output({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_output({tag, ".latency"}, 32'(lat), 32'd4);
        check_output({tag, ".sum"}, 32'(sum), 32'(esum));
        check_output({tag, ".cout"}, 32'(cout), 32'(ecout));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_output({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check_output({tag, ".hold_sum"}, 32'(sum), 32'(esum));
            check_output({tag, ".hold_cout"}, 32'(cout), 32'(ecout));
            check_output({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_output({tag, ".valid_after_hs"}, 32'(out_valid), 32'd0);
        check_output({tag, ".ready_after_hs"}, 32'(in_ready), 32'd1);
        check_output({tag, ".busy_after_hs"}, 32'(busy), 32'd0);
    endtask

    // One operation on the single-slice build.
    task automatic apply_stimulus_4(input logic [3:0] ta, input logic [3:0] tb_b,
                                    input logic tcin, input logic tsub,
                                    input logic [3:0] esum, input logic ecout, input string tag);
        check_output({tag, ".in_ready"}, 32'(in_ready_4), 32'd1);
        a_4 = ta; b_4 = tb_b; cin_4 = tcin; sub_4 = tsub; in_valid_4 = 1'b1;
        @(posedge clk); #1;
        in_valid_4 = 1'b0;
        a_4 = 4'($urandom); b_4 = 4'($urandom); cin_4 = 1'($urandom); sub_4 = 1'($urandom);
        check_output({tag, ".valid_early"}, 32'(out_valid_4), 32'd0);
        @(posedge clk); #1;
        check_output({tag, ".valid"}, 32'(out_valid_4), 32'd1);
        check_output({tag, ".sum"}, 32'(sum_4), 32'(esum));
        check_output({tag, ".cout"}, 32'(cout_4), 32'(ecout));
        out_ready_4 = 1'b1;
        @(posedge clk); #1;
        out_ready_4 = 1'b0;
        check_output({tag, ".ready_after_hs"}, 32'(in_ready_4), 32'd1);
    endtask

    initial begin
        longint msum;
        bit     mcout;
        logic [15:0] ra, rb;
        logic        rc, rs;

        rst_n = 1'b1;
        in_valid = 0; a = '0; b = '0; cin = 0; sub = 0; out_ready = 0;
        in_valid_4 = 0; a_4 = '0; b_4 = '0; cin_4 = 0; sub_4 = 0; out_ready_4 = 0;
        $display("[TB] starting");
        #2 rst_n = 1'b0;
        #1;
        check_output("reset.in_ready", 32'(in_ready), 32'd1);
        check_output("reset.out_valid", 32'(out_valid), 32'd0);
        check_output("reset.busy", 32'(busy), 32'd0);
        check_output("reset.sum", 32'(sum), 32'd0);
        check_output("reset.cout", 32'(cout), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-computed results.
        apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 0, 1'b0, "add_basic");
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, "add_carry_chain");
        apply_stimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0, "sub_borrow");
        apply_stimulus(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, 1'b0, "sub_no_borrow");
        apply_stimulus(16'h0007, 16'h0006, 1'b1, 1'b1, 16'h0000, 1'b1, 0, 1'b0, "sub_cin_equal");
        apply_stimulus(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 3, 1'b0, "backpressure");

        // Reset while slice k=2 is pending: everything drops at once.
        a = 16'hFFFF; b = 16'h0001; cin = 0; sub = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_output("abort.in_ready", 32'(in_ready), 32'd1);
        check_output("abort.out_valid", 32'(out_valid), 32'd0);
        check_output("abort.busy", 32'(busy), 32'd0);
        check_output("abort.sum", 32'(sum), 32'd0);
        check_output("abort.cout", 32'(cout), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check_output("abort.no_stale_valid", 32'(out_valid), 32'd0);
        end
        apply_stimulus(16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 0, 1'b0, "after_abort");

        // Random back-to-back operations with the consumer always ready.
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom);  rs = 1'($urandom);
            if (n == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; rs = 1'b0; end
            if (n == 1) begin ra = 16'h0000; rb = 16'hFFFF; rc = 1'b1; rs = 1'b1; end
            model(16, longint'(ra), longint'(rb), longint'(rc), rs, msum, mcout);
            apply_stimulus(ra, rb, rc, rs, 16'(msum), mcout, 0, 1'b1, "rand16");
        end

        // Single-slice build.
        apply_stimulus_4(4'h9, 4'h8, 1'b1, 1'b0, 4'h2, 1'b1, "w4_directed");
        for (int n = 0; n < 10; n++) begin
            ra = 16'($urandom_range(0, 15)); rb = 16'($urandom_range(0, 15));
            rc = 1'($urandom);  rs = 1'($urandom);
            model(4, longint'(ra), longint'(rb), longint'(rc), rs, msum, mcout);
            apply_stimulus_4(ra[3:0], rb[3:0], rc, rs, 4'(msum), mcout, "w4_rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so a stuck run still ends with a report.
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
